// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 1-bpp frame buffer: line-doubled, horizontally centred image
// with a border, 2-CLK registered pipeline from the raster counters to every output.
module vga_scanout #(
    parameter int          H_IMG_OFS    = 64,
    parameter int          SRC_W        = 512,
    parameter int          SRC_H        = 240,
    parameter logic [11:0] FG_COLOR     = 12'h0F0,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] BORDER_COLOR = 12'h000,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    output logic [13:0] BRAM_RADDR,
    output logic        BRAM_RE,
    input  logic [7:0]  BRAM_RDATA,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE,
    output logic        FRAME_START
);

    localparam int H_ACTIVE       = 640;
    localparam int H_FP           = 16;
    localparam int H_SYNC         = 96;
    localparam int H_BP           = 48;
    localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BYTES_PER_LINE = SRC_W / 8;
    localparam int IMG_ROWS       = 2 * SRC_H;
    // A read issued two counts ahead lands in the shift register exactly as its first pixel arrives.
    localparam int FETCH_FIRST    = H_IMG_OFS - 2;

    logic [9:0]  hCnt_q, hCnt_d;
    logic [9:0]  vCnt_q, vCnt_d;

    logic        hActive, vActive, hSyncOn, vSyncOn;
    logic        imgRow, imgCol, fetchHit, loadHit;
    logic [9:0]  fetchOfs;
    logic [2:0]  pixPhase;
    logic [13:0] fetchAddr;

    logic        de1_q, hs1_q, vs1_q, fs1_q, img1_q, en1_q;
    logic [7:0]  shift_q, shift_d;
    logic        re_q;
    logic [13:0] raddr_q;

    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, de_q, fs_q;

    always_comb begin
        hCnt_d = hCnt_q + 10'd1;
        vCnt_d = vCnt_q;
        if (hCnt_q == 10'(H_TOTAL - 1)) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == 10'(V_TOTAL - 1)) ? '0 : vCnt_q + 10'd1;
        end
    end

    always_comb begin
        hActive   = hCnt_q < 10'(H_ACTIVE);
        vActive   = vCnt_q < 10'(V_ACTIVE);
        hSyncOn   = (hCnt_q >= 10'(H_ACTIVE + H_FP)) && (hCnt_q < 10'(H_ACTIVE + H_FP + H_SYNC));
        vSyncOn   = (vCnt_q >= 10'(V_ACTIVE + V_FP)) && (vCnt_q < 10'(V_ACTIVE + V_FP + V_SYNC));
        imgRow    = vCnt_q < 10'(IMG_ROWS);
        imgCol    = (hCnt_q >= 10'(H_IMG_OFS)) && (hCnt_q < 10'(H_IMG_OFS + SRC_W));
        fetchOfs  = hCnt_q - 10'(FETCH_FIRST);
        pixPhase  = 3'(hCnt_q - 10'(H_IMG_OFS));
        fetchHit  = imgRow && (hCnt_q >= 10'(FETCH_FIRST)) &&
                    (hCnt_q < 10'(FETCH_FIRST + SRC_W)) && (fetchOfs[2:0] == 3'd0);
        loadHit   = imgRow && imgCol && (pixPhase == 3'd0);
        fetchAddr = 14'(vCnt_q[9:1]) * 14'(BYTES_PER_LINE) + 14'(fetchOfs[9:3]);
        shift_d   = loadHit ? BRAM_RDATA : {shift_q[6:0], 1'b0};
    end

    // Stage-1 values are all registered off the same count, so only the colour needs decoding here.
    always_comb begin
        rgb_d = 12'h000;
        if (de1_q && en1_q) begin
            if (img1_q) begin
                rgb_d = shift_q[7] ? FG_COLOR : BG_COLOR;
            end else begin
                rgb_d = BORDER_COLOR;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hCnt_q  <= '0;
            vCnt_q  <= '0;
            de1_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            fs1_q   <= 1'b0;
            img1_q  <= 1'b0;
            en1_q   <= 1'b0;
            shift_q <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hCnt_q  <= hCnt_d;
            vCnt_q  <= vCnt_d;
            de1_q   <= hActive && vActive;
            hs1_q   <= !hSyncOn;
            vs1_q   <= !vSyncOn;
            fs1_q   <= (hCnt_q == 10'd0) && (vCnt_q == 10'(V_ACTIVE));
            img1_q  <= imgRow && imgCol;
            en1_q   <= ENABLE;
            shift_q <= shift_d;
            re_q    <= fetchHit;
            if (fetchHit) begin
                raddr_q <= fetchAddr;
            end
            rgb_q   <= rgb_d;
            hs_q    <= hs1_q;
            vs_q    <= vs1_q;
            de_q    <= de1_q;
            fs_q    <= fs1_q;
        end
    end

    assign BRAM_RE     = re_q;
    assign BRAM_RADDR  = raddr_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_DE      = de_q;
    assign FRAME_START = fs_q;

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of the RX capture stage.
- Reads the 1-bpp frame buffer that RX writes through the BRAM write port (8-bit data, 14-bit address) and generates standard 640x480@60 VGA timing.
- Line-doubles the 512x240 captured image and centres it horizontally inside the 640x480 raster, with a solid border outside the image.
- Drives the monitor connector directly and gives RX a frame-boundary strobe.

Parameters:
- H_IMG_OFS, 64, first displayed column of the image (image spans columns 64..575).
- SRC_W, 512, source image width in pixels; must be a multiple of 8.
- SRC_H, 240, source image height in lines; each line is shown twice (rows 0..479).
- FG_COLOR, 12'h0F0, RGB444 colour for a set pixel.
- BG_COLOR, 12'h000, RGB444 colour for a clear pixel.
- BORDER_COLOR, 12'h000, RGB444 colour for active columns outside the image.

Ports:
- CLK  in  1  pixel clock (25.175 MHz nominal); single clock domain.
- RST_N  in  1  synchronous, active-low reset, sampled on rising CLK.
- ENABLE  in  1  1 = show image; 0 = force RGB to 0 while sync timing keeps running.
- BRAM_RADDR  out  14  frame-buffer read address.
- BRAM_RE  out  1  read enable, one pulse per byte fetched.
- BRAM_RDATA  in  8  read data, valid exactly 1 CLK after the BRAM_RE cycle.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.
- VGA_HS  out  1  horizontal sync, active low.
- VGA_VS  out  1  vertical sync, active low.
- VGA_DE  out  1  1 during the 640x480 active region.
- FRAME_START  out  1  one-CLK pulse on the first clock of vertical blanking (row 480, column 0), aligned with output timing.

Behaviour:
- Counters: internal H counter runs 0..799 and V counter runs 0..524. V increments when H wraps 799->0, and V wraps 524->0.
- Horizontal timing (at outputs): active 0..639, front porch 640..655, sync 656..751 (HS=0), back porch 752..799.
- Vertical timing (at outputs): active 0..479, front porch 480..489, sync 490..491 (VS=0), back porch 492..524.
- Pipeline: all outputs are registered. RGB, HS, VS, DE and FRAME_START are delayed by the same fixed pipeline, so they stay mutually aligned; the fixed latency from counters to outputs is 2 CLK.
- Frame-buffer mapping:
  - Output pixel (x,y) with H_IMG_OFS <= x < H_IMG_OFS+SRC_W and y < 2*SRC_H is bit (7 - ((x-H_IMG_OFS) mod 8)) of the byte at address (y>>1)*(SRC_W/8) + ((x-H_IMG_OFS)>>3). MSB is the leftmost pixel.
  - Bit 1 gives FG_COLOR, bit 0 gives BG_COLOR.
- Fetch: exactly SRC_W/8 = 64 BRAM_RE pulses per displayed row, at 8-CLK spacing, with consecutive addresses. No reads occur in blanking or border columns. Rows 2n and 2n+1 read the same address range.
- Data handling: the fetched byte loads into an 8-bit shift register that shifts once per pixel. The next byte is fetched early enough that there is no gap between byte boundaries.
- Address width: 240*64 = 15360 bytes, so the maximum address is 15359 (14'h3BFF). Addresses 15360..16383 are never read.
- Regions:
  - Active columns outside the image output BORDER_COLOR.
  - Rows 480..524 and columns 640..799 output RGB=0 with DE=0.
- ENABLE=0: RGB=0 on every pixel, starting with the first pixel whose pipeline sample saw ENABLE=0. HS, VS, DE and FRAME_START are unaffected. BRAM_RE continues as normal, so re-enabling mid-line is seamless.
- Reset values: H=0, V=0, VGA_HS=1, VGA_VS=1, VGA_DE=0, RGB=0, BRAM_RE=0, BRAM_RADDR=0, FRAME_START=0, shift register=0.
- Reset mid-frame: takes effect on the next CLK edge. The current line is aborted with no partial reads after the reset. After RST_N returns high, output timing restarts at pixel (0,0) 2 CLK later.
- Simultaneous H and V wrap (H=799, V=524): the next cycle is (0,0) and the read for row 0 proceeds as normal.

Test Plan:
- Reset held 10 CLK, then released, run 2 frames -> HS period 800 CLK with 96 low; VS period 420000 CLK with 1600 CLK low; DE high 640 CLK per line, 480 lines; FRAME_START once per 420000 CLK at row 480, column 0.
- BRAM model (1-CLK latency) with every byte = 8'hAA, ENABLE=1 -> row 0 columns 64..575 alternate 0F0/000 starting with 0F0; columns 0..63 and 576..639 are 000.
- Byte at address 64 = 8'h80, all others 8'h00 -> exactly pixels (64,2) and (64,3) are FG; 64 BRAM_RE pulses per row, addresses 64..127 on rows 2 and 3.
- Full frame read -> last read address is 14'h3BFF during row 479; zero reads in rows 480..524; 30720 BRAM_RE pulses per frame.
- ENABLE dropped at row 100, column 300 for one line -> RGB=0 from that point until ENABLE returns; HS, VS and DE waveforms identical to the reference run.
- RST_N pulsed low for 1 CLK at row 200, column 400 -> next output frame begins at (0,0) 2 CLK after release; outputs hold reset values during reset.
